// File: rtl/div_seq_if.sv
// div_seq_if: start/done handshake and result bus for the sequential divider.
//   master : drives div_init, signed_op, value_A (dividend), value_B (divisor);
//            observes busy, done, div_zero, hi (remainder), lo (quotient).
//   slave  : the divider side of the same signals.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             div_init;
  logic             signed_op;
  logic [WIDTH-1:0] value_A;
  logic [WIDTH-1:0] value_B;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output div_init, signed_op, value_A, value_B,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  div_init, signed_op, value_A, value_B,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multicycle restoring divider for the HI/LO unit.
//   lo = quotient, hi = remainder (remainder takes the dividend's sign,
//   quotient truncates toward zero in signed mode).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - div_seq_if.slave: div_init/signed_op/value_A/value_B in,
//           busy/done/div_zero/hi/lo out
// Latency: start accepted at edge E0, hi/lo written at E(WIDTH+1), done high
// for the following cycle.
// Optional build macro DIV_ZERO_CHECK_EN: a zero divisor skips the iteration,
// returns hi = dividend, lo = all ones and raises div_zero (done after 1 cycle).
// Without it div_zero is tied low and a zero divisor runs the full algorithm.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     reset,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] dvd;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic             take;
  logic             last;

  assign start = (state == IDLE) && bus.div_init;
  assign a_neg = bus.signed_op & bus.value_A[WIDTH-1];
  assign b_neg = bus.signed_op & bus.value_B[WIDTH-1];
  // MIN negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  assign a_mag = a_neg ? -bus.value_A : bus.value_A;
  assign b_mag = b_neg ? -bus.value_B : bus.value_B;

  // rem < dvs holds between steps, so rem_sh < 2*dvs and the difference is
  // below 2^WIDTH whenever it is non-negative: WIDTH+1 bits suffice.
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign take   = ~diff[WIDTH];
  assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
  logic b_zero;
  logic dz_q;
  assign b_zero       = (bus.value_B == '0);
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_CHECK_EN
          state_nxt = b_zero ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:  if (last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            dvd   <= a_mag;
            dvs   <= b_mag;
            cnt   <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
`ifdef DIV_ZERO_CHECK_EN
            dz_q  <= b_zero;
            if (b_zero) begin
              hi_q <= bus.value_A;
              lo_q <= '1;
            end
`endif
          end
        end
        RUN: begin
          rem <= take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], take};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          lo_q <= q_neg ? -dvd : dvd;
          hi_q <= r_neg ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Parametrised multicycle restoring divider for the datapath's HI/LO unit; successor to the fixed 32-bit divider.
- Supports signed and unsigned operation, a start/done handshake, a busy flag and configurable width.
- Follows the MIPS convention: `lo` = quotient, `hi` = remainder.
- Sits beside the multiplier and is driven by the control FSM via `div_init`.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- div_init  input  1  start request; sampled only in IDLE.
- signed_op  input  1  1 = signed (two's complement), 0 = unsigned; latched with operands.
- value_A  input  WIDTH  dividend; latched on accepted start.
- value_B  input  WIDTH  divisor; latched on accepted start.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse; results valid.
- div_zero  output  1  divisor-was-zero flag for the last operation.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, done and div_zero = 0.
  - hi, lo and all internal registers = 0.
  - Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with div_init=1, latch operands and signed_op.
  - Store magnitudes: |A| and |B| if signed_op, else raw values.
  - Record the quotient sign (sA^sB) and the remainder sign (sA).
  - Clear the partial remainder; counter=0; go to RUN.
- RUN, one quotient bit per clock, MSB first:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor from rem in WIDTH+1 bits.
  - If non-negative, keep the difference and shift in 1; else shift in 0.
  - After WIDTH iterations (counter == WIDTH-1), go to FIX.
- FIX:
  - Quotient negated if signed_op and the quotient sign = 1.
  - Remainder negated if signed_op and the dividend was negative.
  - Write `lo`/`hi`; go to DONE.
- DONE: done=1 for this single cycle, then IDLE.
- Latency: start accepted at edge E0; `hi`/`lo` updated at edge E(WIDTH+1); done high during the following cycle (WIDTH+2 cycles start-to-done).
- `hi`/`lo`/`div_zero` hold their values until the next operation writes them.
- div_init while busy or in DONE is ignored; it is not queued.
- div_init held high re-triggers from IDLE (back-to-back operations, one idle cycle between them).
- Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow, MIN/-1 (signed): lo=MIN, hi=0, no flag (falls out of the magnitude arithmetic).
- Unsigned 0/x: lo=0, hi=0.

Optional Feature:
- Macro: DIV_ZERO_CHECK_EN.
- Defined:
  - In IDLE, value_B==0 on an accepted start goes directly to DONE.
  - `hi` = the dividend as presented, `lo` = all ones, div_zero=1.
  - done pulses the cycle after the start edge (latency 1); busy never asserts.
  - div_zero clears on the next accepted start.
- Not defined:
  - No early exit; div_zero is tied 0.
  - A zero divisor runs the full WIDTH+2 latency.
  - The result is whatever the algorithm yields: magnitude quotient all ones, remainder |A|, then the normal FIX sign rules.
  - Unsigned case: lo=0xFFFFFFFF, hi=A.

Test Plan (WIDTH=32 unless noted):
- Unsigned 100/7, start pulse → busy for 33 cycles; done in cycle 34 after start; lo=14, hi=2; held after done.
- Signed -7/2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Signed 7/-2 → lo=-3, hi=1.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Unsigned 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- Divide 1234/0:
  - With DIV_ZERO_CHECK_EN: done the cycle after start, div_zero=1, hi=1234, lo=0xFFFFFFFF.
  - Without: done at 34 cycles, div_zero=0, lo=0xFFFFFFFF, hi=1234.
- Start 1000/3, pulse div_init again at cycle 10 (ignored), then pull reset low at cycle 20:
  - busy/done/hi/lo go to 0 asynchronously; no done pulse.
  - Release reset, start 9/3 → lo=3, hi=0.
- WIDTH=8, unsigned 200/13 → lo=15, hi=5, done 10 cycles after start.
